// File: rtl/csr_rmw_ctrl_if.sv
// rtl/csr_rmw_ctrl_if.sv - request, register-file and response signals of the CSR read-modify-write sequencer
interface csr_rmw_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_op_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_operand_i;
    logic              req_src_zero_i;
    logic [ADDR_W-1:0] csr_raddr_o;
    logic [DATA_W-1:0] csr_rdata_i;
    logic              csr_we_o;
    logic [ADDR_W-1:0] csr_waddr_o;
    logic [DATA_W-1:0] csr_wdata_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_operand_i, req_src_zero_i,
        input  csr_rdata_i, rsp_ready_i,
        output req_ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_operand_i, req_src_zero_i,
        output csr_rdata_i, rsp_ready_i,
        input  req_ready_o, csr_raddr_o, csr_we_o, csr_waddr_o, csr_wdata_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/csr_rmw_ctrl.sv
// rtl/csr_rmw_ctrl.sv - CSRRW/CSRRS/CSRRC read-modify-write sequencer; optional CSR_RO_CHECK_EN blocks writes to read-only CSRs
module csr_rmw_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    csr_rmw_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] operand_q;
    logic              zero_q;
    logic [DATA_W-1:0] rdata_q;

    logic              would_write;
    logic              wr_blocked;
    logic [DATA_W-1:0] new_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addr_q    <= '0;
            operand_q <= '0;
            zero_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.req_valid_i) begin
                op_q      <= bus.req_op_i;
                addr_q    <= bus.req_addr_i;
                operand_q <= bus.req_operand_i;
                zero_q    <= bus.req_src_zero_i;
            end
            if (state_q == S_WB) begin
                rdata_q <= bus.csr_rdata_i;
            end
        end
    end

    // Set/clear with a zero source must not write, so side effects of the write are skipped.
    always_comb begin
        would_write = 1'b0;
        new_data    = operand_q;
        case (op_q)
            OP_RW: begin
                would_write = 1'b1;
                new_data    = operand_q;
            end
            OP_RS: begin
                would_write = !zero_q;
                new_data    = bus.csr_rdata_i | operand_q;
            end
            OP_RC: begin
                would_write = !zero_q;
                new_data    = bus.csr_rdata_i & ~operand_q;
            end
            default: begin
                would_write = 1'b0;
                new_data    = operand_q;
            end
        endcase
    end

`ifdef CSR_RO_CHECK_EN
    assign wr_blocked = would_write && (addr_q[11:10] == 2'b11);
`else
    assign wr_blocked = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.req_valid_i) state_d = S_RD;
            S_RD:   state_d = S_WB;
            S_WB:   state_d = S_RESP;
            S_RESP: if (bus.rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.csr_raddr_o = addr_q;
    assign bus.csr_waddr_o = addr_q;
    assign bus.csr_wdata_o = new_data;
    assign bus.csr_we_o    = (state_q == S_WB) && would_write && !wr_blocked && !rst;
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = (state_q == S_RESP) && ((op_q == 2'b00) || wr_blocked);

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// tb/tb_csr_rmw_ctrl.sv - directed self-checking bench for csr_rmw_ctrl with a registered CSR file model
module tb_csr_rmw_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    csr_rmw_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    csr_rmw_ctrl #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // CSR file model: synchronous read with one cycle latency, preload port for setup
    logic [31:0] mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        bus.csr_rdata_i <= mem[bus.csr_raddr_o[11:0]];
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.csr_we_o) begin
            mem[bus.csr_waddr_o[11:0]] <= bus.csr_wdata_o;
            wr_count <= wr_count + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the RD cycle.
    task automatic start_req(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] operand, input logic zero);
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = op;
        bus.req_addr_i     = addr;
        bus.req_operand_i  = operand;
        bus.req_src_zero_i = zero;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    // From RD negedge through WB and RESP, then the handshake back to IDLE.
    task automatic finish_req(input string tag, input logic [31:0] addr, input logic exp_we,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                              input logic exp_err);
        chk({tag, "_rd_raddr"}, bus.csr_raddr_o, addr);
        chk({tag, "_rd_ready"}, {31'd0, bus.req_ready_o}, 32'd0);
        chk({tag, "_rd_we"}, {31'd0, bus.csr_we_o}, 32'd0);
        @(negedge clk);
        chk({tag, "_wb_we"}, {31'd0, bus.csr_we_o}, {31'd0, exp_we});
        if (exp_we) begin
            chk({tag, "_wb_waddr"}, bus.csr_waddr_o, addr);
            chk({tag, "_wb_wdata"}, bus.csr_wdata_o, exp_wdata);
        end
        chk({tag, "_wb_rspv"}, {31'd0, bus.rsp_valid_o}, 32'd0);
        @(negedge clk);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid_o}, 32'd1);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata_o, exp_rdata);
        chk({tag, "_rsp_err"}, {31'd0, bus.rsp_err_o}, {31'd0, exp_err});
        chk({tag, "_rsp_we"}, {31'd0, bus.csr_we_o}, 32'd0);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk({tag, "_idle_ready"}, {31'd0, bus.req_ready_o}, 32'd1);
        chk({tag, "_idle_rspv"}, {31'd0, bus.rsp_valid_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    int wr_before;

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_op_i       = 2'b00;
        bus.req_addr_i     = '0;
        bus.req_operand_i  = '0;
        bus.req_src_zero_i = 1'b0;
        bus.rsp_ready_i    = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_we_in_reset", {31'd0, bus.csr_we_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_rspv", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("rst_err", {31'd0, bus.rsp_err_o}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rst_raddr", bus.csr_raddr_o, 32'd0);

        preload(12'h340, 32'h12345678);
        preload(12'h300, 32'h0);
        preload(12'h304, 32'h888);
        preload(12'hF14, 32'h0);

        // CSRRW mscratch returns old value, then a set-with-zero re-read sees the new value
        start_req(2'b01, 32'h340, 32'hDEADBEEF, 1'b0);
        finish_req("rw340", 32'h340, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b0);
        start_req(2'b10, 32'h340, 32'h0, 1'b1);
        finish_req("reread340", 32'h340, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

        start_req(2'b10, 32'h300, 32'h8, 1'b0);
        finish_req("rs300", 32'h300, 1'b1, 32'h8, 32'h0, 1'b0);
        wr_before = wr_count;
        start_req(2'b10, 32'h300, 32'h8, 1'b1);
        finish_req("rs300_zero", 32'h300, 1'b0, 32'h0, 32'h8, 1'b0);
        chk("rs300_zero_nowrite", wr_count - wr_before, 32'd0);

        start_req(2'b11, 32'h304, 32'h80, 1'b0);
        finish_req("rc304", 32'h304, 1'b1, 32'h808, 32'h888, 1'b0);
        start_req(2'b10, 32'h304, 32'h0, 1'b1);
        finish_req("reread304", 32'h304, 1'b0, 32'h0, 32'h808, 1'b0);

        // Upper address bits pass through to the register file ports
        start_req(2'b01, 32'hA000_0300, 32'h3, 1'b0);
        finish_req("upper_addr", 32'hA000_0300, 1'b1, 32'h3, 32'h8, 1'b0);

        // Response back-pressure with a competing request held upstream
        start_req(2'b01, 32'h340, 32'h1, 1'b0);
        @(negedge clk);
        chk("stall_wb_we", {31'd0, bus.csr_we_o}, 32'd1);
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_op_i       = 2'b10;
        bus.req_addr_i     = 32'h300;
        bus.req_operand_i  = 32'h0;
        bus.req_src_zero_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rspv", {31'd0, bus.rsp_valid_o}, 32'd1);
            chk("stall_rdata", bus.rsp_rdata_o, 32'hDEADBEEF);
            chk("stall_ready", {31'd0, bus.req_ready_o}, 32'd0);
            chk("stall_raddr", bus.csr_raddr_o, 32'h340);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        chk("stall_post_idle", {31'd0, bus.req_ready_o}, 32'd1);
        chk("stall_post_raddr", bus.csr_raddr_o, 32'h340);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        finish_req("stall_next", 32'h300, 1'b0, 32'h0, 32'h3, 1'b0);

        // Reset asserted during WB aborts the write and the response
        wr_before = wr_count;
        start_req(2'b01, 32'h340, 32'h77, 1'b0);
        @(negedge clk);
        chk("rstwb_we_pre", {31'd0, bus.csr_we_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwb_we_forced", {31'd0, bus.csr_we_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwb_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rstwb_rspv", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("rstwb_rdata", bus.rsp_rdata_o, 32'd0);
        chk("rstwb_nowrite", wr_count - wr_before, 32'd0);
        @(negedge clk);
        chk("rstwb_idle_rspv", {31'd0, bus.rsp_valid_o}, 32'd0);
        start_req(2'b10, 32'h340, 32'h0, 1'b1);
        finish_req("rstwb_reread", 32'h340, 1'b0, 32'h0, 32'h1, 1'b0);

        // Reserved op: no write, error flagged, old value returned
        wr_before = wr_count;
        start_req(2'b00, 32'h340, 32'hFFFF, 1'b0);
        finish_req("op00", 32'h340, 1'b0, 32'h0, 32'h1, 1'b1);
        chk("op00_nowrite", wr_count - wr_before, 32'd0);

`ifdef CSR_RO_CHECK_EN
        start_req(2'b01, 32'hF14, 32'h5, 1'b0);
        finish_req("ro_f14", 32'hF14, 1'b0, 32'h0, 32'h0, 1'b1);
        start_req(2'b10, 32'hF14, 32'h0, 1'b1);
        finish_req("ro_f14_rs0", 32'hF14, 1'b0, 32'h0, 32'h0, 1'b0);
`else
        start_req(2'b01, 32'hF14, 32'h5, 1'b0);
        finish_req("ro_f14", 32'hF14, 1'b1, 32'h5, 32'h0, 1'b0);
        start_req(2'b10, 32'hF14, 32'h0, 1'b1);
        finish_req("ro_f14_rs0", 32'hF14, 1'b0, 32'h0, 32'h5, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- CSR access sequencer between the execute stage and the CSR register file; runs CSRRW/CSRRS/CSRRC as a read-modify-write.
- Accepts one CSR request via valid/ready and drives the register file's read address. Captures the registered read data one cycle later, computes and issues the write, then returns the old CSR value for rd writeback.
- One request in flight; back-pressure is through req_ready_o.

Parameters:
- DATA_W, 32, CSR data width (RegBus).
- ADDR_W, 32, CSR address bus width (DataAddrBus); only [11:0] is significant, upper bits are passed through unchanged.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-high (RstEnable)
- req_valid_i  input  1  CSR request valid
- req_ready_o  output  1  high only in IDLE
- req_op_i  input  2  01=RW, 10=RS (set), 11=RC (clear), 00=reserved
- req_addr_i  input  ADDR_W  CSR address
- req_operand_i  input  DATA_W  rs1 value or zero-extended zimm
- req_src_zero_i  input  1  rs1 index or zimm is zero
- csr_raddr_o  output  ADDR_W  to register file read address
- csr_rdata_i  input  DATA_W  register file read data, registered with 1-cycle latency
- csr_we_o  output  1  register file write enable
- csr_waddr_o  output  ADDR_W  write address
- csr_wdata_o  output  DATA_W  write data
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response accepted
- rsp_rdata_o  output  DATA_W  old CSR value
- rsp_err_o  output  1  request was illegal

Behaviour:
- Reset:
  - State=IDLE.
  - Outputs: req_ready_o=1, csr_we_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - Registers: addr_q, op_q, operand_q, zero_q, rdata_q all 0.
  - csr_we_o is forced 0 in any cycle where rst=1, including reset asserted during WB.
  - Reset in any state aborts the request without a write or a response.
- IDLE:
  - On req_valid_i, capture op/addr/operand/src_zero into the *_q registers and go to RD.
  - req_ready_o=1 only in IDLE.
- csr_raddr_o:
  - Equals addr_q in all states.
  - The register file samples it at the end of RD.
- RD: one cycle, then go to WB.
- WB:
  - csr_rdata_i is valid this cycle; latch it into rdata_q.
  - Write data:
    - RW: new = operand_q.
    - RS: new = rdata | operand_q.
    - RC: new = rdata & ~operand_q.
  - Write enable: csr_we_o=1 when the op is legal and NOT ((RS or RC) and zero_q).
    - RW always writes.
    - op 00 never writes.
  - csr_waddr_o=addr_q and csr_wdata_o=new. csr_waddr_o and csr_wdata_o are don't-care when csr_we_o=0.
  - Go to RESP.
- RESP:
  - rsp_valid_o=1, rsp_rdata_o=rdata_q, and rsp_err_o is set if op_q==00.
  - Hold all three until rsp_ready_i=1, then go to IDLE.
  - The next request is accepted no earlier than the cycle after the handshake.
- Latency: accept at cycle N, write committed at the end of N+2, rsp_valid_o from N+3.
  - Throughput is one request per 4 cycles when rsp_ready_i is held at 1.
- A request arriving while not in IDLE is not accepted; upstream holds it.
- Response and write use the pre-write value: a CSRRW on mscratch returns the old mscratch.

Optional Feature:
- Macro: CSR_RO_CHECK_EN.
- Defined:
  - When addr_q[11:10]==2'b11 (read-only CSR) and a write would occur, the write is suppressed (csr_we_o=0) and rsp_err_o=1.
  - rsp_rdata_o still returns the read value.
  - RS/RC with zero_q on a read-only address is legal: no error, no write.
- Not defined:
  - No address check; writes are issued to any address.
  - rsp_err_o is driven only for op 00.

Test Plan:
- RW 0x340 (mscratch) operand 0xDEADBEEF, previous value 0x12345678 -> we pulse at N+2 with wdata 0xDEADBEEF; rsp 0x12345678 at N+3; re-read returns 0xDEADBEEF.
- RS 0x300 (mstatus) operand 0x8, src_zero=0, current 0x0 -> wdata 0x8; rsp 0x0. Repeat with src_zero=1 -> csr_we_o stays 0.
- RC 0x304 (mie) operand 0x80, current 0x888 -> wdata 0x808; rsp 0x888.
- rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable; req_ready_o=0; a new req_valid_i is not accepted until the cycle after the handshake.
- rst asserted during WB -> no write, no response; the next cycle is IDLE with req_ready_o=1. op 00 -> no write, rsp_err_o=1.
- With CSR_RO_CHECK_EN: RW 0xF14 (mhartid) operand 0x5 -> no write, rsp_err_o=1, rsp 0x0. Without the macro -> write is issued, rsp_err_o=0.
